// File: rtl/prf_nxm_2w2r_init.sv
// Parametrised 2-write / 2-read register file with per-bit write masks, optional bypass and
// zero entry, and a built-in sequencer that clears the array after reset or on request.
module prf_nxm_2w2r_init #(
  parameter int DATA_WIDTH = 32,
  parameter int WORD_COUNT = 32,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1,
  localparam int AW        = $clog2(WORD_COUNT)
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic                  CLRN,
  output logic                  READY,
  input  logic                  WEC,
  input  logic [DATA_WIDTH-1:0] BWC,
  input  logic [DATA_WIDTH-1:0] DC,
  input  logic [AW-1:0]         AC,
  input  logic                  WED,
  input  logic [DATA_WIDTH-1:0] BWD,
  input  logic [DATA_WIDTH-1:0] DD,
  input  logic [AW-1:0]         AD,
  input  logic [AW-1:0]         AA,
  output logic [DATA_WIDTH-1:0] QA,
  input  logic [AW-1:0]         AB,
  output logic [DATA_WIDTH-1:0] QB
);

  typedef enum logic {ST_INIT, ST_RUN} state_e;

  state_e                r_state;
  state_e                w_state_nxt;
  logic [AW-1:0]         r_cnt;
  logic [AW-1:0]         w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_mem [WORD_COUNT];
  logic [DATA_WIDTH-1:0] w_nv  [WORD_COUNT];
  logic                  w_run;
  logic                  w_c_ok;
  logic                  w_d_ok;
  logic [DATA_WIDTH-1:0] w_mc;
  logic [DATA_WIDTH-1:0] w_md;
  logic                  w_a_ok;
  logic                  w_b_ok;

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // NOTE: defaults first so no path through the block leaves a variable unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_INIT: begin
        if (r_cnt == AW'(WORD_COUNT - 1)) begin
          w_state_nxt = ST_RUN;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + AW'(1);
        end
      end
      ST_RUN: begin
        if (!CLRN) begin
          w_state_nxt = ST_INIT;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_run = (r_state == ST_RUN);
  assign READY = w_run;

  // Effective per-port masks; out-of-range addresses drop the whole port.
  assign w_c_ok = w_run && !WEC && (int'(AC) < WORD_COUNT);
  assign w_d_ok = w_run && !WED && (int'(AD) < WORD_COUNT);
  assign w_mc   = w_c_ok ? ~BWC : '0;
  assign w_md   = w_d_ok ? ~BWD : '0;

  always_comb begin : nv_calc
    logic [DATA_WIDTH-1:0] mc_i;
    logic [DATA_WIDTH-1:0] md_i;
    for (int i = 0; i < WORD_COUNT; i++) begin
      mc_i    = (AC == AW'(i)) ? w_mc : '0;
      md_i    = (AD == AW'(i)) ? w_md : '0;
      w_nv[i] = (r_mem[i] & ~(mc_i | md_i)) | (DC & mc_i & ~md_i) | (DD & md_i);
    end
  end

  // NOTE: the array has no reset; the INIT sequencer clears it, keeping it RAM-like.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < WORD_COUNT; i++) begin
      if (r_state == ST_INIT) begin
        if (r_cnt == AW'(i)) r_mem[i] <= '0;
      end else if (!(ZERO_REG != 0 && i == 0)) begin
        r_mem[i] <= w_nv[i];
      end
    end
  end

  assign w_a_ok = w_run && (int'(AA) < WORD_COUNT) && !(ZERO_REG != 0 && AA == '0);
  assign w_b_ok = w_run && (int'(AB) < WORD_COUNT) && !(ZERO_REG != 0 && AB == '0);

  always_comb begin
    QA = '0;
    QB = '0;
    if (w_a_ok) QA = (BYPASS != 0) ? w_nv[AA] : r_mem[AA];
    if (w_b_ok) QB = (BYPASS != 0) ? w_nv[AB] : r_mem[AB];
  end

endmodule

// File: tb/tb_prf_nxm_2w2r_init.sv
// Self-checking bench for prf_nxm_2w2r_init: directed scenarios plus randomized traffic,
// all outputs compared each cycle against a behavioural model of the register file.
module tb_prf_nxm_2w2r_init;

  localparam int DW  = 32;
  localparam int WC  = 32;
  localparam int AW  = $clog2(WC);
  localparam int BYP = 1;
  localparam int ZR  = 1;

  logic          CLK;
  logic          RESETN;
  logic          CLRN;
  logic          READY;
  logic          WEC, WED;
  logic [DW-1:0] BWC, BWD, DC, DD;
  logic [AW-1:0] AC, AD, AA, AB;
  logic [DW-1:0] QA, QB;

  prf_nxm_2w2r_init #(
    .DATA_WIDTH(DW), .WORD_COUNT(WC), .BYPASS(BYP), .ZERO_REG(ZR)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .CLRN(CLRN), .READY(READY),
    .WEC(WEC), .BWC(BWC), .DC(DC), .AC(AC),
    .WED(WED), .BWD(BWD), .DD(DD), .AD(AD),
    .AA(AA), .QA(QA), .AB(AB), .QB(QB)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: array contents, ready flag, remaining clear cycles.
  logic [DW-1:0] m_mem [WC];
  bit            m_ready   = 1'b0;
  int            m_left    = WC;
  bit            chk_en    = 1'b0;

  // Entry value after this cycle's writes: C applied first, then D overrides its own bits.
  function automatic logic [DW-1:0] m_next(input int addr);
    logic [DW-1:0] v;
    v = m_mem[addr];
    for (int b = 0; b < DW; b++) begin
      if (!WEC && int'(AC) == addr && !BWC[b]) v[b] = DC[b];
      if (!WED && int'(AD) == addr && !BWD[b]) v[b] = DD[b];
    end
    return v;
  endfunction

  function automatic logic [DW-1:0] m_read(input int addr);
    if (!(RESETN && m_ready) || addr >= WC || (ZR != 0 && addr == 0)) return '0;
    return (BYP != 0) ? m_next(addr) : m_mem[addr];
  endfunction

  always @(posedge CLK) begin
    if (!RESETN) begin
      m_ready = 1'b0;
      m_left  = WC;
    end else if (!m_ready) begin
      m_left--;
      if (m_left == 0) begin
        m_ready = 1'b1;
        for (int a = 0; a < WC; a++) m_mem[a] = '0;
      end
    end else begin
      for (int a = (ZR != 0) ? 1 : 0; a < WC; a++) m_mem[a] = m_next(a);
      if (!CLRN) begin
        m_ready = 1'b0;
        m_left  = WC;
      end
    end
  end

  always @(negedge CLK) begin
    if (chk_en) begin
      check("ready", DW'(READY), DW'(RESETN && m_ready));
      check("qa", QA, m_read(int'(AA)));
      check("qb", QB, m_read(int'(AB)));
    end
  end

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    CLRN = 1'b1;
    WEC  = 1'b1;
    WED  = 1'b1;
    BWC  = '1;
    BWD  = '1;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    while (!READY && n < 100) begin
      cyc();
      n++;
    end
    check(name, DW'(n), DW'(WC));
  endtask

  initial begin
    RESETN = 1'b0;
    idle();
    DC = '0; DD = '0; AC = '0; AD = '0; AA = '0; AB = '0;
    repeat (3) cyc();
    chk_en = 1'b1;
    check("reset_ready", DW'(READY), '0);
    check("reset_qa", QA, '0);

    // Clear sequence after reset release, then every entry reads 0.
    RESETN = 1'b1;
    wait_ready("init_len");
    check("model_ready", DW'(m_ready), DW'(1));
    for (int a = 0; a < WC; a++) begin
      AA = AW'(a);
      AB = AW'(WC - 1 - a);
      @(negedge CLK);
      check("init_zero_a", QA, '0);
      check("init_zero_b", QB, '0);
      cyc();
    end

    // Single port C write with bypass and then stored.
    WEC = 1'b0; AC = 5; DC = 32'hDEADBEEF; BWC = '0; AA = 5;
    @(negedge CLK);
    check("bypass_c", QA, 32'hDEADBEEF);
    cyc();
    idle();
    @(negedge CLK);
    check("stored_c", QA, 32'hDEADBEEF);
    check("model_e5", m_mem[5], 32'hDEADBEEF);

    // Same-address collision with partial masks.
    cyc();
    WEC = 1'b0; AC = 7; DC = 32'hFFFFFFFF; BWC = '0;
    cyc();
    WEC = 1'b0; AC = 7; DC = 32'h00000000; BWC = 32'hFFFF0000;
    WED = 1'b0; AD = 7; DD = 32'h12345678; BWD = 32'hFFFFFF00;
    AA = 7;
    @(negedge CLK);
    check("collide_byp", QA, 32'hFFFF0078);
    cyc();
    idle();
    @(negedge CLK);
    check("collide", QA, 32'hFFFF0078);
    check("model_e7", m_mem[7], 32'hFFFF0078);

    // Zero entry ignores writes, bypass included.
    cyc();
    WEC = 1'b0; AC = 0; DC = 32'hAAAA5555; BWC = '0; AA = 0;
    @(negedge CLK);
    check("zero_byp", QA, '0);
    cyc();
    idle();
    @(negedge CLK);
    check("zero_after", QA, '0);

    // Clear request: writes during the clear are lost, entry 3 reads 0 afterwards.
    cyc();
    WEC = 1'b0; AC = 3; DC = 32'h1; BWC = '0;
    cyc();
    idle();
    AA = 3;
    CLRN = 1'b0;
    cyc();
    CLRN = 1'b1;
    check("clr_ready_low", DW'(READY), '0);
    WEC = 1'b0; AC = 3; DC = 32'hFFFFFFFF; BWC = '0;
    wait_ready("clr_len");
    idle();
    @(negedge CLK);
    check("clr_e3", QA, '0);

    // Reset in the middle of the clear sequence restarts it from scratch.
    cyc();
    RESETN = 1'b0;
    cyc();
    RESETN = 1'b1;
    repeat (10) cyc();
    RESETN = 1'b0;
    repeat (3) cyc();
    check("midinit_ready", DW'(READY), '0);
    RESETN = 1'b1;
    wait_ready("reinit_len");

    // Randomized traffic, checked every cycle by the compare process.
    for (int k = 0; k < 3000; k++) begin
      WEC  = ($urandom_range(0, 3) == 0);
      WED  = ($urandom_range(0, 3) == 0);
      AC   = AW'($urandom_range(0, WC - 1));
      AD   = ($urandom_range(0, 2) == 0) ? AC : AW'($urandom_range(0, WC - 1));
      DC   = $urandom;
      DD   = $urandom;
      BWC  = ($urandom_range(0, 1) == 0) ? '0 : DW'($urandom);
      BWD  = ($urandom_range(0, 1) == 0) ? '0 : DW'($urandom);
      AA   = ($urandom_range(0, 2) == 0) ? AC : AW'($urandom_range(0, WC - 1));
      AB   = ($urandom_range(0, 2) == 0) ? AD : AW'($urandom_range(0, WC - 1));
      CLRN = ($urandom_range(0, 199) != 0);
      cyc();
    end
    idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
